// File: rtl/serial_adder_defs.sv
// Shared definitions for the bit-serial adder: state encoding and counter sizing.
package serial_adder_defs;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
   function automatic int clog2_min1(input int w);
      return (w <= 1) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder; the only arithmetic in the serial datapath.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, LSB first, one bit per clock through a single fa_cell.
module serial_adder
   import serial_adder_defs::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int            CW   = clog2_min1(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_sa, r_sb, r_res, w_res_nxt;
   logic [CW-1:0]    r_cnt;
   logic             r_carry, r_cmsb;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout, r_ovf, r_done;
   logic             w_accept, w_last, w_s, w_c;

   assign w_accept = (r_state == S_IDLE) && start;
   assign w_last   = (r_state == S_BUSY) && (r_cnt == LAST);

   fa_cell u_fa (
      .a  (r_sa[0]),
      .b  (r_sb[0]),
      .ci (r_carry),
      .s  (w_s),
      .co (w_c)
   );

   // Result bits enter from the MSB end so the word is aligned after WIDTH shifts.
   always_comb begin
      w_res_nxt            = r_res >> 1;
      w_res_nxt[WIDTH-1]   = w_s;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start)  w_state_nxt = S_BUSY;
         S_BUSY:  if (w_last) w_state_nxt = S_IDLE;
         default:             w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sa    <= '0;
         r_sb    <= '0;
         r_res   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_cmsb  <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_accept) begin
            // Subtract as A + ~B + 1; cin then acts as a borrow-in.
            r_sa    <= a;
            r_sb    <= sub ? ~b : b;
            r_carry <= cin ^ sub;
            r_cmsb  <= cin ^ sub;
            r_cnt   <= '0;
         end else if (r_state == S_BUSY) begin
            r_sa    <= r_sa >> 1;
            r_sb    <= r_sb >> 1;
            r_res   <= w_res_nxt;
            r_carry <= w_c;
            if (!w_last) begin
               r_cnt  <= r_cnt + 1'b1;
               r_cmsb <= w_c;
            end else begin
               r_sum  <= w_res_nxt;
               r_cout <= w_c;
               r_ovf  <= w_c ^ r_cmsb;
            end
         end
      end
   end

   assign busy     = (r_state == S_BUSY);
   assign done     = r_done;
   assign sum      = r_sum;
   assign cout     = r_cout;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Randomised and directed checks of serial_adder against an integer-arithmetic model.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         sub = 1'b0, cin = 1'b0;
   logic         busy, done, cout, overflow;
   logic [W-1:0] sum;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_done_cyc = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .sub      (sub),
      .cin      (cin),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .cout     (cout),
      .overflow (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns {overflow, cout, sum} from plain integer arithmetic.
   function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic msub, input logic mcin);
      int ua, ub, sa, sb, ur, sr;
      logic [W-1:0] s;
      logic c, v;
      ua = int'(ma);
      ub = int'(mb);
      sa = int'($signed(ma));
      sb = int'($signed(mb));
      if (!msub) begin
         ur = ua + ub + int'(mcin);
         sr = sa + sb + int'(mcin);
         c  = (ur > 255);
      end else begin
         ur = ua - ub - int'(mcin);
         sr = sa - sb - int'(mcin);
         c  = (ur >= 0);
      end
      s = ur[W-1:0];
      v = (sr > 127) || (sr < -128);
      return {v, c, s};
   endfunction

   // Call away from a clock edge; leaves start high when keep is set.
   task automatic op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                     input logic osub, input logic ocin, input bit keep);
      logic [W+1:0] e;
      int n;
      e = model(oa, ob, osub, ocin);
      a = oa; b = ob; sub = osub; cin = ocin; start = 1'b1;
      @(posedge clk); #1;
      chk("busy_after_accept", busy, 1);
      if (!keep) start = 1'b0;
      a = W'($urandom); b = W'($urandom); sub = ~osub; cin = ~ocin;
      n = 0;
      while (!done && n < 20) begin
         chk("busy_during", busy, 1);
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n, W);
      chk("busy_at_done", busy, 0);
      chk("sum", sum, e[W-1:0]);
      chk("cout", cout, e[W]);
      chk("overflow", overflow, e[W+1]);
      last_done_cyc = cyc;
   endtask

   initial begin
      logic [W-1:0] hold_sum;
      int first_done;
      int seen_done;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", overflow, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      op(8'h3C, 8'h0F, 0, 0, 0);
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
      chk("sum_held", sum, 8'h4B);
      op(8'hFF, 8'h01, 0, 0, 0);
      op(8'hFF, 8'h01, 0, 1, 0);
      op(8'h7F, 8'h01, 0, 0, 0);
      op(8'h80, 8'hFF, 0, 0, 0);
      op(8'h05, 8'h07, 1, 0, 0);
      op(8'h07, 8'h05, 1, 1, 0);
      op(8'h80, 8'h01, 1, 0, 0);

      // start held through the operation, then a back-to-back accept in the done cycle
      op(8'h5A, 8'h33, 0, 1, 1);
      first_done = last_done_cyc;
      op(8'h12, 8'h34, 1, 0, 0);
      chk("back_to_back_gap", last_done_cyc - first_done, W + 1);

      // idle with start low: outputs hold, no done
      hold_sum = sum;
      repeat (3) begin
         @(posedge clk); #1;
         chk("idle_busy", busy, 0);
         chk("idle_sum", sum, hold_sum);
      end

      // asynchronous reset mid-operation
      a = 8'hAA; b = 8'h11; sub = 0; cin = 0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_sum", sum, 0);
      chk("midrst_cout", cout, 0);
      chk("midrst_ovf", overflow, 0);
      seen_done = 0;
      repeat (2) begin
         @(negedge clk);
         if (done) seen_done++;
      end
      rst = 1'b0;
      repeat (W + 2) begin
         @(negedge clk);
         if (done) seen_done++;
      end
      chk("midrst_no_done", seen_done, 0);
      op(8'h10, 8'h20, 0, 0, 0);

      // reset together with start: reset wins
      @(negedge clk);
      rst = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      chk("rst_start_busy", busy, 0);
      @(negedge clk);
      start = 1'b0; rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 30; i++) begin
         op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
         start = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation ran past limit");
      $fatal(1, "timeout");
   end

endmodule
